// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
// Read-side drain engine for the asynchronous FIFO. Lives entirely in the
// read clock domain. It pops words from the FIFO head with rinc whenever
// there is room in a 2-entry output buffer. Buffered words are presented as
// a valid/ready stream, with a frame-boundary marker and a delivered-word
// counter.
//
// Ports:
//   rclk      read-domain clock
//   rrst_n    asynchronous active-low reset
//   rdata     FIFO head word (valid combinationally while rempty=0)
//   rempty    FIFO empty flag
//   rinc      FIFO pop strobe (combinational from registered occupancy)
//   enable    1 = pops allowed; buffered words always drain
//   m_data    output stream data (head slot)
//   m_valid   output word valid (occupancy != 0)
//   m_ready   downstream accept
//   m_last    current output word closes a frame of FRAME_LEN words
//   rd_count  words accepted downstream, modulo 2^CNTW
module fifo_rd_stream #(
   parameter int DSIZE     = 8,
   parameter int FRAME_LEN = 4,
   parameter int CNTW      = 16
) (
   input  logic             rclk,
   input  logic             rrst_n,
   input  logic [DSIZE-1:0] rdata,
   input  logic             rempty,
   output logic             rinc,
   input  logic             enable,
   output logic [DSIZE-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             m_last,
   output logic [CNTW-1:0]  rd_count
);

   localparam int FCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAME_LEN - 1);

   logic [DSIZE-1:0] head_r, tail_r, head_nxt_s, tail_nxt_s;
   logic [1:0]       occ_r, occ_nxt_s;
   logic [FCW-1:0]   frame_cnt_r, frame_cnt_nxt_s;
   logic [CNTW-1:0]  rd_count_r, rd_count_nxt_s;
   logic             pop_s;
   logic             hs_s;

   // The buffer logic uses the pop decision without rrst_n: while reset is
   // low every register is held cleared anyway. Only the strobe leaving the
   // block is gated, so the FIFO never sees a pop during reset.
   assign pop_s    = enable & ~rempty & (occ_r < 2'd2);
   assign rinc     = rrst_n & pop_s;
   assign m_valid  = (occ_r != 2'd0);
   assign hs_s     = m_valid & m_ready;
   assign m_data   = head_r;
   assign m_last   = m_valid & (frame_cnt_r == FRAME_LAST);
   assign rd_count = rd_count_r;

   // Buffer next state: slot steering and occupancy update.
   always_comb begin
      head_nxt_s = head_r;
      tail_nxt_s = tail_r;
      occ_nxt_s  = occ_r;
      case (occ_r)
         2'd0: begin
            if (pop_s) begin
               head_nxt_s = rdata;
               occ_nxt_s  = 2'd1;
            end else begin
               occ_nxt_s  = 2'd0;
            end
         end
         2'd1: begin
            if (pop_s && hs_s) begin
               // Head leaves and the new word takes its place in one cycle.
               head_nxt_s = rdata;
               occ_nxt_s  = 2'd1;
            end else if (pop_s) begin
               tail_nxt_s = rdata;
               occ_nxt_s  = 2'd2;
            end else if (hs_s) begin
               occ_nxt_s  = 2'd0;
            end else begin
               occ_nxt_s  = 2'd1;
            end
         end
         2'd2: begin
            // No pop is possible when full, so only a handshake moves state.
            if (hs_s) begin
               head_nxt_s = tail_r;
               occ_nxt_s  = 2'd1;
            end else begin
               occ_nxt_s  = 2'd2;
            end
         end
         default: begin
            occ_nxt_s = 2'd0;
         end
      endcase
   end

   // Frame position and delivered-word count advance on each handshake.
   always_comb begin
      frame_cnt_nxt_s = frame_cnt_r;
      rd_count_nxt_s  = rd_count_r;
      if (hs_s) begin
         rd_count_nxt_s = rd_count_r + CNTW'(1);
         if (frame_cnt_r == FRAME_LAST) begin
            frame_cnt_nxt_s = {FCW{1'b0}};
         end else begin
            frame_cnt_nxt_s = frame_cnt_r + FCW'(1);
         end
      end else begin
         frame_cnt_nxt_s = frame_cnt_r;
      end
   end

   // State registers; reset discards all buffered words and counts.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         head_r      <= {DSIZE{1'b0}};
         tail_r      <= {DSIZE{1'b0}};
         occ_r       <= 2'd0;
         frame_cnt_r <= {FCW{1'b0}};
         rd_count_r  <= {CNTW{1'b0}};
      end else begin
         head_r      <= head_nxt_s;
         tail_r      <= tail_nxt_s;
         occ_r       <= occ_nxt_s;
         frame_cnt_r <= frame_cnt_nxt_s;
         rd_count_r  <= rd_count_nxt_s;
      end
   end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Testbench for fifo_rd_stream (DSIZE=8, FRAME_LEN=4, CNTW=4).
// A queue models the FIFO contents. Each word pushed also pushes its expected
// {last, data} into a scoreboard. A monitor compares the scoreboard against
// every handshake, checks that rinc never fires while rempty is set, and
// checks that the output holds steady under backpressure.
module tb_fifo_rd_stream;

   logic       rclk;
   logic       rrst_n;
   logic [7:0] rdata;
   logic       rempty;
   logic       rinc;
   logic       enable;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic       m_last;
   logic [3:0] rd_count;

   fifo_rd_stream #(.DSIZE(8), .FRAME_LEN(4), .CNTW(4)) dut (
      .rclk(rclk), .rrst_n(rrst_n), .rdata(rdata), .rempty(rempty),
      .rinc(rinc), .enable(enable), .m_data(m_data), .m_valid(m_valid),
      .m_ready(m_ready), .m_last(m_last), .rd_count(rd_count)
   );

   initial begin
      rclk = 1'b0;
      forever #5 rclk = ~rclk;
   end

   logic [7:0] fifo_q[$];
   logic [8:0] exp_q[$];
   int         psn;
   int         pop_cnt;
   int         total;
   int         bad;

   logic       prev_valid, prev_ready, prev_last;
   logic [7:0] prev_data;
   logic [8:0] e;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic void refresh();
      rempty = (fifo_q.size() == 0);
      rdata  = rempty ? 8'h00 : fifo_q[0];
   endfunction

   task automatic push_word(input logic [7:0] d);
      fifo_q.push_back(d);
      exp_q.push_back({((psn % 4) == 3) ? 1'b1 : 1'b0, d});
      psn++;
      refresh();
   endtask

   task automatic step();
      @(negedge rclk);
      refresh();
   endtask

   task automatic do_reset();
      step();
      rrst_n = 1'b0;
      fifo_q.delete();
      exp_q.delete();
      psn = 0;
      refresh();
      step();
      step();
      rrst_n  = 1'b1;
      pop_cnt = 0;
   endtask

   // Monitor: runs between edges, looking at what the next rising edge samples.
   always @(negedge rclk) begin
      #2;
      if (!rrst_n) begin
         prev_valid = 1'b0;
      end else begin
         if (rempty) chk("no_pop_when_empty", {31'd0, rinc}, 32'd0);
         if (prev_valid && !prev_ready) begin
            chk("hold_valid", {31'd0, m_valid}, 32'd1);
            chk("hold_data", {24'd0, m_data}, {24'd0, prev_data});
            chk("hold_last", {31'd0, m_last}, {31'd0, prev_last});
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_word: got %0h expected none", m_data);
            end else begin
               e = exp_q.pop_front();
               chk("data", {24'd0, m_data}, {24'd0, e[7:0]});
               chk("last", {31'd0, m_last}, {31'd0, e[8]});
            end
         end
         if (rinc) begin
            pop_cnt++;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
         end
         prev_valid = m_valid;
         prev_ready = m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
      end
   end

   initial begin
      int sent;
      total = 0; bad = 0; psn = 0; pop_cnt = 0;
      prev_valid = 1'b0; prev_ready = 1'b0; prev_data = 8'h00; prev_last = 1'b0;
      rrst_n = 1'b0; enable = 1'b1; m_ready = 1'b1;
      refresh();

      // Basic 3-word stream; the words wait in the FIFO while reset is held.
      push_word(8'h11); push_word(8'h22); push_word(8'h33);
      step();
      #1;
      chk("rst_valid", {31'd0, m_valid}, 32'd0);
      chk("rst_data", {24'd0, m_data}, 32'd0);
      chk("rst_last", {31'd0, m_last}, 32'd0);
      chk("rst_count", {28'd0, rd_count}, 32'd0);
      chk("rst_rinc", {31'd0, rinc}, 32'd0);
      step();
      rrst_n = 1'b1;
      pop_cnt = 0;
      repeat (4) step();
      #1;
      chk("basic_count", {28'd0, rd_count}, 32'd3);
      chk("basic_valid_off", {31'd0, m_valid}, 32'd0);
      chk("basic_pops", pop_cnt, 32'd3);
      chk("basic_drained", exp_q.size(), 32'd0);

      // Backpressure: only two pops, then a gap-free drain.
      do_reset();
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++) push_word(8'hA0 + 8'(i));
      repeat (4) step();
      #1;
      chk("bp_pops", pop_cnt, 32'd2);
      chk("bp_rinc_low", {31'd0, rinc}, 32'd0);
      chk("bp_valid", {31'd0, m_valid}, 32'd1);
      chk("bp_head", {24'd0, m_data}, 32'hA0);
      step();
      m_ready = 1'b1;
      #1;
      chk("bp_rinc_still_low", {31'd0, rinc}, 32'd0);
      step();
      #1;
      chk("bp_rinc_resume", {31'd0, rinc}, 32'd1);
      repeat (4) step();
      #1;
      chk("bp_count", {28'd0, rd_count}, 32'd5);
      chk("bp_valid_off", {31'd0, m_valid}, 32'd0);
      chk("bp_total_pops", pop_cnt, 32'd5);

      // Frames: words 4, 8 and 12 carry m_last.
      do_reset();
      m_ready = 1'b1;
      for (int i = 0; i < 10; i++) push_word(8'h40 + 8'(i));
      repeat (12) step();
      #1;
      chk("frame_count10", {28'd0, rd_count}, 32'd10);
      chk("frame_drained", exp_q.size(), 32'd0);
      push_word(8'h5A); push_word(8'h5B);
      repeat (4) step();
      #1;
      chk("frame_count12", {28'd0, rd_count}, 32'd12);

      // Random backpressure and random fill over 1000 words.
      do_reset();
      sent = 0;
      for (int cyc = 0; cyc < 10000 && (sent < 1000 || exp_q.size() > 0); cyc++) begin
         step();
         m_ready = 1'($urandom_range(0, 1));
         if (sent < 1000 && $urandom_range(0, 1) == 1) begin
            push_word(8'($urandom_range(0, 255)));
            sent++;
         end
      end
      m_ready = 1'b1;
      #1;
      chk("rand_drained", exp_q.size(), 32'd0);
      chk("rand_count", {28'd0, rd_count}, 32'd8);

      // Dropping enable with the buffer full: the two buffered words drain.
      do_reset();
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_word(8'hB0 + 8'(i));
      repeat (3) step();
      #1;
      chk("en_pops_full", pop_cnt, 32'd2);
      step();
      enable  = 1'b0;
      m_ready = 1'b1;
      #1;
      chk("en_rinc_off", {31'd0, rinc}, 32'd0);
      repeat (3) step();
      #1;
      chk("en_valid_off", {31'd0, m_valid}, 32'd0);
      chk("en_count", {28'd0, rd_count}, 32'd2);
      chk("en_pops", pop_cnt, 32'd2);
      chk("en_left", exp_q.size(), 32'd2);

      // Counter wrap after 17 words, then reset with a full buffer.
      do_reset();
      enable  = 1'b1;
      m_ready = 1'b1;
      for (int i = 0; i < 17; i++) push_word(8'h01 + 8'(i));
      repeat (20) step();
      #1;
      chk("wrap_count", {28'd0, rd_count}, 32'd1);
      step();
      m_ready = 1'b0;
      push_word(8'h81); push_word(8'h82); push_word(8'h83);
      repeat (3) step();
      #1;
      chk("wrap_pops", pop_cnt, 32'd19);
      chk("wrap_valid", {31'd0, m_valid}, 32'd1);
      step();
      rrst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, m_valid}, 32'd0);
      chk("mid_rst_count", {28'd0, rd_count}, 32'd0);
      chk("mid_rst_rinc", {31'd0, rinc}, 32'd0);
      chk("mid_rst_data", {24'd0, m_data}, 32'd0);
      chk("mid_rst_last", {31'd0, m_last}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
